// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers line/frame timing from active-low hsync/vsync,
// declares lock once timing is stable, and regenerates x_px/y_px/activevideo.
// Optional feature: define VGA_SYNC_DEC_CDC_EN to add a two-flop synchronizer
// ahead of the input sample registers (latency 2 -> 4 cycles).
`timescale 1ns/1ps

module vga_sync_decoder #(
    parameter int unsigned HSTART      = 95,
    parameter int unsigned VSTART      = 19,
    parameter int unsigned ACTIVE_H    = 320,
    parameter int unsigned ACTIVE_V    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       activevideo,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       new_frame
);

    localparam logic [9:0]  CNT_MAX  = 10'd1023;
    localparam logic [3:0]  LOCK_TGT = 4'(LOCK_FRAMES);
    localparam logic [10:0] H_LO     = 11'(HSTART);
    localparam logic [10:0] H_HI     = 11'(HSTART + ACTIVE_H);
    localparam logic [10:0] V_LO     = 11'(VSTART);
    localparam logic [10:0] V_HI     = 11'(VSTART + ACTIVE_V);

    logic       h_samp_q, v_samp_q, h_prev_q, v_prev_q;
    logic       fall_h, fall_v;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic       vpend_q, vpend_d, frame_bad_q, frame_bad_d;
    logic       locked_q, locked_d, new_frame_q, new_frame_d;
    logic [3:0] stable_q, stable_d, stable_inc;
    logic [9:0] hcnt_inc, vcnt_inc;
    logic       line_bad, h_in, v_in;

`ifdef VGA_SYNC_DEC_CDC_EN
    logic h_meta_q, v_meta_q, h_sync_q, v_sync_q;

    // Two-flop synchronizer for sync inputs that may be asynchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_meta_q <= 1'b1;
            v_meta_q <= 1'b1;
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
        end else begin
            h_meta_q <= hsync_in;
            v_meta_q <= vsync_in;
            h_sync_q <= h_meta_q;
            v_sync_q <= v_meta_q;
        end
    end
`else
    logic h_sync_q, v_sync_q;

    // Inputs are synchronous to clk, so the sample stage takes them directly.
    always_comb begin
        h_sync_q = hsync_in;
        v_sync_q = vsync_in;
    end
`endif

    // Sample and previous-sample registers; idle level is high so reset never fakes an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_samp_q <= 1'b1;
            v_samp_q <= 1'b1;
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true pipeline.
            h_samp_q <= h_sync_q;
            v_samp_q <= v_sync_q;
            h_prev_q <= h_samp_q;
            v_prev_q <= v_samp_q;
        end
    end

    assign fall_h     = h_prev_q & ~h_samp_q;
    assign fall_v     = v_prev_q & ~v_samp_q;
    assign hcnt_inc   = hcnt_q + 10'd1;
    assign vcnt_inc   = vcnt_q + 10'd1;
    assign line_bad   = fall_h && (hcnt_inc != line_len_q);
    assign stable_inc = (stable_q >= LOCK_TGT) ? LOCK_TGT : stable_q + 4'd1;

    // Counter, measurement and lock-evaluation next-state logic.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value unassigned (no latches).
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        vpend_d       = vpend_q | fall_v;
        frame_bad_d   = frame_bad_q;
        locked_d      = locked_q;
        stable_d      = stable_q;
        new_frame_d   = 1'b0;

        if (fall_h) begin
            hcnt_d     = '0;
            line_len_d = hcnt_inc;
            if (line_bad) begin
                frame_bad_d = 1'b1;
                locked_d    = 1'b0;
            end
            // A vsync edge coinciding with this hsync edge makes this line vcnt=0.
            if (vpend_q | fall_v) begin
                vcnt_d        = '0;
                frame_lines_d = vcnt_inc;
                vpend_d       = 1'b0;
                new_frame_d   = 1'b1;
                frame_bad_d   = 1'b0;
                if ((vcnt_inc == frame_lines_q) && !frame_bad_q && !line_bad) begin
                    stable_d = stable_inc;
                    if (stable_inc == LOCK_TGT) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    stable_d = '0;
                    locked_d = 1'b0;
                end
            end else begin
                vcnt_d = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_inc;
            end
        end else begin
            hcnt_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_inc;
        end

        // A saturated counter means the sync source has gone away.
        if ((hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX)) begin
            locked_d = 1'b0;
            stable_d = '0;
        end
    end

    // State register for counters, measurements and lock status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            vpend_q       <= 1'b0;
            frame_bad_q   <= 1'b0;
            locked_q      <= 1'b0;
            stable_q      <= '0;
            new_frame_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            vpend_q       <= vpend_d;
            frame_bad_q   <= frame_bad_d;
            locked_q      <= locked_d;
            stable_q      <= stable_d;
            new_frame_q   <= new_frame_d;
        end
    end

    // Active-window decode and pixel coordinates, combinational from the counters.
    always_comb begin
        h_in        = ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI);
        v_in        = ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
        activevideo = locked_q & h_in & v_in;
        x_px        = activevideo ? (hcnt_q - H_LO[9:0]) : '0;
        y_px        = activevideo ? (vcnt_q - V_LO[9:0]) : '0;
    end

    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign new_frame   = new_frame_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives vga_sync_decoder from a behavioural sync
// generator and compares the recovered pixel stream through a latency queue.
// Honours VGA_SYNC_DEC_CDC_EN for the expected end-to-end latency.
`timescale 1ns/1ps

module tb_vga_sync_decoder;

    // Scaled-down raster so the whole sequence stays short.
    localparam int H_TOT     = 200;
    localparam int H_STRETCH = 210;
    localparam int HPULSE    = 16;
    localparam int HSTART    = 40;
    localparam int AH        = 128;
    localparam int V_TOT     = 16;
    localparam int VPULSE    = 2;
    localparam int VSTART    = 4;
    localparam int AV        = 10;
    localparam int FRAME     = H_TOT * V_TOT;
`ifdef VGA_SYNC_DEC_CDC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
    } pix_t;

    logic       clk;
    logic       resetn;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x_px;
    logic [9:0] y_px;
    logic       activevideo;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;
    logic       new_frame;

    int checks   = 0;
    int failures = 0;

    // Generator state (written only by the generator process).
    int   g_h;
    int   g_v;
    int   g_hlen;
    pix_t g_pix;
    // Generator controls (written only by the test sequence).
    bit   hold_h       = 1'b0;
    int   stretch_line = -1;
    bit   cmp_en       = 1'b0;

    // Scoreboard statistics (written only by the scoreboard).
    pix_t sb_q[$];
    int   act_cnt = 0;
    int   max_x   = 0;
    int   max_y   = 0;
    int   min_x   = 1023;
    int   min_y   = 1023;

    vga_sync_decoder #(
        .HSTART      (HSTART),
        .VSTART      (VSTART),
        .ACTIVE_H    (AH),
        .ACTIVE_V    (AV),
        .LOCK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .x_px        (x_px),
        .y_px        (y_px),
        .activevideo (activevideo),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .new_frame   (new_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_gen();
        logic a;
        hsync_in = hold_h ? 1'b1 : (g_h >= HPULSE);
        vsync_in = (g_v >= VPULSE);
        a = (g_h >= HSTART) && (g_h < HSTART + AH) && (g_v >= VSTART) && (g_v < VSTART + AV);
        g_pix.act = a;
        g_pix.x   = a ? 10'(g_h - HSTART) : 10'd0;
        g_pix.y   = a ? 10'(g_v - VSTART) : 10'd0;
    endtask

    // Reference sync generator: one step per clock, outputs change just after the edge.
    initial begin
        g_h    = 0;
        g_v    = 0;
        g_hlen = H_TOT;
        drive_gen();
        forever begin
            @(posedge clk);
            #1;
            g_h++;
            if (g_h >= g_hlen) begin
                g_h    = 0;
                g_v    = (g_v == V_TOT - 1) ? 0 : g_v + 1;
                g_hlen = (g_v == stretch_line) ? H_STRETCH : H_TOT;
            end
            drive_gen();
        end
    end

    // Scoreboard: push the generator's pixel each cycle, pop it LAT cycles later.
    always @(negedge clk) begin
        pix_t e;
        sb_q.push_back(g_pix);
        if (sb_q.size() > LAT) begin
            e = sb_q.pop_front();
            if (cmp_en) begin
                check("sb_pix", {11'd0, activevideo, x_px, y_px}, {11'd0, e});
                if (activevideo) begin
                    act_cnt++;
                    if (int'(x_px) > max_x) max_x = int'(x_px);
                    if (int'(y_px) > max_y) max_y = int'(y_px);
                    if (int'(x_px) < min_x) min_x = int'(x_px);
                    if (int'(y_px) < min_y) min_y = int'(y_px);
                end
            end
        end
    end

    task automatic wait_nf(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!new_frame && n < 2 * FRAME);
        check(tag, {31'd0, new_frame}, 32'd1);
        @(negedge clk);
        check({tag, "_width"}, {31'd0, new_frame}, 32'd0);
    endtask

    task automatic wait_lock(input string tag, input int max_cyc);
        int n = 0;
        while (!locked && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, locked}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_nf"}, {31'd0, new_frame}, 32'd0);
        check({tag, "_act"}, {31'd0, activevideo}, 32'd0);
        check({tag, "_x"}, {22'd0, x_px}, 32'd0);
        check({tag, "_y"}, {22'd0, y_px}, 32'd0);
        check({tag, "_len"}, {22'd0, line_len}, 32'd0);
        check({tag, "_lines"}, {22'd0, frame_lines}, 32'd0);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        repeat (4) @(negedge clk);
        resetn = 1'b1;

        // Lock acquisition from reset.
        for (int i = 0; i < 4; i++) wait_nf("t1_nf");
        check("t1_locked", {31'd0, locked}, 32'd1);
        check("t1_line_len", {22'd0, line_len}, 32'(H_TOT));
        check("t1_frame_lines", {22'd0, frame_lines}, 32'(V_TOT));

        // One full frame against the delayed generator stream.
        wait_nf("t2_nf");
        #1 cmp_en = 1'b1;
        repeat (FRAME) @(negedge clk);
        #1 cmp_en = 1'b0;
        check("t2_act_cnt", act_cnt, 32'(AH * AV));
        check("t2_max_x", max_x, 32'(AH - 1));
        check("t2_min_x", min_x, 32'd0);
        check("t2_max_y", max_y, 32'(AV - 1));
        check("t2_min_y", min_y, 32'd0);

        // hsync held high: lock must drop once hcnt saturates.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (g_h != H_TOT - 1 && n < 2 * H_TOT);
        check("t3_pre_locked", {31'd0, locked}, 32'd1);
        hold_h = 1'b1;
        repeat (700) @(negedge clk);
        check("t3_early_locked", {31'd0, locked}, 32'd1);
        repeat (400) @(negedge clk);
        check("t3_lost_locked", {31'd0, locked}, 32'd0);
        check("t3_lost_act", {31'd0, activevideo}, 32'd0);
        check("t3_lost_x", {22'd0, x_px}, 32'd0);
        check("t3_lost_y", {22'd0, y_px}, 32'd0);
        hold_h = 1'b0;
        wait_lock("t3_relock", 8 * FRAME);
        check("t3_line_len", {22'd0, line_len}, 32'(H_TOT));

        // One stretched line mid-frame.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (g_v != 1 && n < 2 * FRAME);
        check("t4_pre_locked", {31'd0, locked}, 32'd1);
        stretch_line = 6;
        n = 0;
        while (locked && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t4_drop", {31'd0, locked}, 32'd0);
        check("t4_line_len", {22'd0, line_len}, 32'(H_STRETCH));
        stretch_line = -1;
        wait_nf("t4_nf_bad");
        check("t4_bad_frame_unlocked", {31'd0, locked}, 32'd0);
        wait_nf("t4_nf_clean1");
        check("t4_clean1_unlocked", {31'd0, locked}, 32'd0);
        wait_nf("t4_nf_clean2");
        check("t4_relock", {31'd0, locked}, 32'd1);

        // Asynchronous reset in the middle of active video.
        n = 0;
        while (!activevideo && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t5_pre_act", {31'd0, activevideo}, 32'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_all_zero("t5_async");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_lock("t5_relock", 8 * FRAME);
        check("t5_line_len", {22'd0, line_len}, 32'(H_TOT));
        check("t5_frame_lines", {22'd0, frame_lines}, 32'(V_TOT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
